// File: rtl/pwm_timer_ctrl_if.sv
// Register-write port and comparator-side outputs of the PWM timer sequencer.
interface pwm_timer_ctrl_if #(
  parameter int unsigned Width = 16
);
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [Width-1:0] wr_data;
  logic [Width-1:0] cnt;
  logic [Width-1:0] period_act;
  logic [Width-1:0] ccr_act;
  logic [Width-1:0] ccr_on_act;
  logic             enable;
  logic             busy;
  logic             pending;
  logic             period_tick;
  logic             irq;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  cnt, period_act, ccr_act, ccr_on_act, enable, busy, pending, period_tick, irq
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output cnt, period_act, ccr_act, ccr_on_act, enable, busy, pending, period_tick, irq
  );
endinterface

// File: rtl/pwm_timer_ctrl.sv
// PWM sequencer: free-running counter plus shadow/active PERIOD, CCR, CCR_ON registers.
// Define PWM_IRQ_EN to build the sticky period interrupt; otherwise IRQ is tied low.
module pwm_timer_ctrl #(
  parameter int unsigned Width     = 16,
  parameter int unsigned RstPeriod = 1000
) (
  input logic             clk_i,
  input logic             rst_ni,
  pwm_timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] per_sh_q, per_sh_d, ccr_sh_q, ccr_sh_d, ccr_on_sh_q, ccr_on_sh_d;
  logic [Width-1:0] per_act_q, per_act_d, ccr_act_q, ccr_act_d, ccr_on_act_q, ccr_on_act_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             ctrl_wr, shadow_wr, run_bit, force_upd, wrap, start, load;

  assign ctrl_wr   = bus.wr_en && (bus.wr_addr == 2'd3);
  assign shadow_wr = bus.wr_en && (bus.wr_addr != 2'd3);
  assign run_bit   = bus.wr_data[0];
  assign force_upd = bus.wr_data[1];

  // A period of 0 or 1 degenerates to a wrap on every cycle.
  assign wrap  = (state_q != StIdle) &&
                 ((per_act_q <= Width'(1)) || (cnt_q == per_act_q - Width'(1)));
  assign start = (state_q == StIdle) && ctrl_wr && run_bit;
  assign load  = (ctrl_wr && force_upd) || (pending_q && (wrap || start));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) state_d = StRun;
      end
      StRun: begin
        cnt_d = wrap ? '0 : cnt_q + Width'(1);
        if (ctrl_wr && !run_bit) state_d = StDrain;
      end
      StDrain: begin
        cnt_d = wrap ? '0 : cnt_q + Width'(1);
        if (ctrl_wr && run_bit) state_d = StRun;
        else if (wrap)          state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Active copies always take the pre-write shadow; a coincident write stays pending.
  always_comb begin
    per_act_d    = load ? per_sh_q    : per_act_q;
    ccr_act_d    = load ? ccr_sh_q    : ccr_act_q;
    ccr_on_act_d = load ? ccr_on_sh_q : ccr_on_act_q;
    per_sh_d     = (shadow_wr && bus.wr_addr == 2'd0) ? bus.wr_data : per_sh_q;
    ccr_sh_d     = (shadow_wr && bus.wr_addr == 2'd1) ? bus.wr_data : ccr_sh_q;
    ccr_on_sh_d  = (shadow_wr && bus.wr_addr == 2'd2) ? bus.wr_data : ccr_on_sh_q;
    pending_d    = shadow_wr ? 1'b1 : (load ? 1'b0 : pending_q);
    tick_d       = wrap;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      per_sh_q     <= Width'(RstPeriod);
      ccr_sh_q     <= '0;
      ccr_on_sh_q  <= '0;
      per_act_q    <= Width'(RstPeriod);
      ccr_act_q    <= '0;
      ccr_on_act_q <= '0;
      pending_q    <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      per_sh_q     <= per_sh_d;
      ccr_sh_q     <= ccr_sh_d;
      ccr_on_sh_q  <= ccr_on_sh_d;
      per_act_q    <= per_act_d;
      ccr_act_q    <= ccr_act_d;
      ccr_on_act_q <= ccr_on_act_d;
      pending_q    <= pending_d;
      tick_q       <= tick_d;
    end
  end

`ifdef PWM_IRQ_EN
  logic irq_clr, irq_q, irq_d;

  assign irq_clr = bus.wr_data[2];

  // Set wins over a clear in the same cycle.
  always_comb begin
    irq_d = irq_q;
    if (wrap)                    irq_d = 1'b1;
    else if (ctrl_wr && irq_clr) irq_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= irq_d;
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

  assign bus.cnt         = cnt_q;
  assign bus.period_act  = per_act_q;
  assign bus.ccr_act     = ccr_act_q;
  assign bus.ccr_on_act  = ccr_on_act_q;
  assign bus.enable      = (state_q != StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.pending     = pending_q;
  assign bus.period_tick = tick_q;

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Self-checking bench for pwm_timer_ctrl: directed table, corner sequences, random vs. model.
module tb_pwm_timer_ctrl;

`ifdef PWM_IRQ_EN
  localparam bit IrqOn = 1'b1;
`else
  localparam bit IrqOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pwm_timer_ctrl_if #(.Width(16)) bus ();

  pwm_timer_ctrl #(.Width(16), .RstPeriod(1000)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Reference model state: mode 0 idle, 1 run, 2 drain; index 0 PERIOD, 1 CCR, 2 CCR_ON.
  int       m_mode;
  int       m_cnt;
  int       m_sh[3];
  int       m_act[3];
  bit       m_pend, m_tick, m_irq;

  function automatic void model_reset();
    m_mode = 0; m_cnt = 0; m_pend = 0; m_tick = 0; m_irq = 0;
    m_sh[0] = 1000; m_act[0] = 1000;
    for (int i = 1; i < 3; i++) begin m_sh[i] = 0; m_act[i] = 0; end
  endfunction

  function automatic void model_step(bit we, int a, int d);
    bit ctrl, wrap, start, load;
    ctrl  = we && (a == 3);
    wrap  = (m_mode != 0) && ((m_act[0] < 2) || (m_cnt + 1 == m_act[0]));
    start = (m_mode == 0) && ctrl && d[0];
    load  = (ctrl && d[1]) || (m_pend && (wrap || start));
    m_tick = wrap;
    if (IrqOn) begin
      if (wrap) m_irq = 1;
      else if (ctrl && d[2]) m_irq = 0;
    end
    if (m_mode == 0 || wrap) m_cnt = 0;
    else m_cnt = (m_cnt + 1) % 65536;
    case (m_mode)
      0: if (start) m_mode = 1;
      1: if (ctrl && !d[0]) m_mode = 2;
      default: if (ctrl && d[0]) m_mode = 1; else if (wrap) m_mode = 0;
    endcase
    if (load) for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
    if (we && a < 3) begin m_sh[a] = d; m_pend = 1; end
    else if (load) m_pend = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model cnt", 32'(bus.cnt), m_cnt);
    chk("model period_act", 32'(bus.period_act), m_act[0]);
    chk("model ccr_act", 32'(bus.ccr_act), m_act[1]);
    chk("model ccr_on_act", 32'(bus.ccr_on_act), m_act[2]);
    chk("model enable", 32'(bus.enable), 32'(m_mode != 0));
    chk("model busy", 32'(bus.busy), 32'(m_mode != 0));
    chk("model pending", 32'(bus.pending), 32'(m_pend));
    chk("model tick", 32'(bus.period_tick), 32'(m_tick));
    chk("model irq", 32'(bus.irq), 32'(m_irq));
  endtask

  // Called at a negedge; leaves with outputs of the following posedge settled.
  task automatic drive(input bit we, input int a, input int d);
    bus.wr_en   = we;
    bus.wr_addr = 2'(a);
    bus.wr_data = 16'(d);
    @(posedge clk);
    model_step(we, a, d);
    @(negedge clk);
    bus.wr_en = 1'b0;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  typedef struct {
    bit we; int a; int d;
    int e_cnt; bit e_en; bit e_pend; bit e_tick; int e_per; int e_ccr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1, 0, 5, 0, 0, 1, 0, 1000, 0};
    vecs[1]  = '{1, 1, 2, 0, 0, 1, 0, 1000, 0};
    vecs[2]  = '{1, 3, 1, 0, 1, 0, 0, 5, 2};
    vecs[3]  = '{0, 0, 0, 1, 1, 0, 0, 5, 2};
    vecs[4]  = '{0, 0, 0, 2, 1, 0, 0, 5, 2};
    vecs[5]  = '{0, 0, 0, 3, 1, 0, 0, 5, 2};
    vecs[6]  = '{0, 0, 0, 4, 1, 0, 0, 5, 2};
    vecs[7]  = '{0, 0, 0, 0, 1, 0, 1, 5, 2};
    vecs[8]  = '{0, 0, 0, 1, 1, 0, 0, 5, 2};
    vecs[9]  = '{1, 1, 4, 2, 1, 1, 0, 5, 2};
    vecs[10] = '{0, 0, 0, 3, 1, 1, 0, 5, 2};
    vecs[11] = '{0, 0, 0, 4, 1, 1, 0, 5, 2};
    vecs[12] = '{0, 0, 0, 0, 1, 0, 1, 5, 4};

    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 16'd0;
    model_reset();
    #12;
    check_model();
    chk("reset period_act", 32'(bus.period_act), 1000);
    @(negedge clk);
    rst_n = 1'b1;

    // Start-up, counting, tick, and deferred CCR update.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].we, vecs[i].a, vecs[i].d);
      chk($sformatf("vec%0d cnt", i), 32'(bus.cnt), vecs[i].e_cnt);
      chk($sformatf("vec%0d enable", i), 32'(bus.enable), 32'(vecs[i].e_en));
      chk($sformatf("vec%0d pending", i), 32'(bus.pending), 32'(vecs[i].e_pend));
      chk($sformatf("vec%0d tick", i), 32'(bus.period_tick), 32'(vecs[i].e_tick));
      chk($sformatf("vec%0d period_act", i), 32'(bus.period_act), vecs[i].e_per);
      chk($sformatf("vec%0d ccr_act", i), 32'(bus.ccr_act), vecs[i].e_ccr);
    end

    // Drain completes the current period before going idle.
    drive(1, 0, 8);
    idle(4);
    chk("drain period_act 8", 32'(bus.period_act), 8);
    idle(3);
    drive(1, 3, 0);
    chk("drain cnt 4", 32'(bus.cnt), 4);
    chk("drain busy", 32'(bus.busy), 1);
    idle(3);
    chk("drain cnt 7", 32'(bus.cnt), 7);
    chk("drain enable at 7", 32'(bus.enable), 1);
    idle(1);
    chk("drain idle enable", 32'(bus.enable), 0);
    chk("drain idle cnt", 32'(bus.cnt), 0);
    idle(2);
    chk("idle cnt held", 32'(bus.cnt), 0);

    // Shadow write coinciding with a wrap.
    drive(1, 0, 4);
    drive(1, 3, 1);
    idle(1);
    drive(1, 0, 6);
    idle(1);
    drive(1, 0, 10);
    chk("wrap-write period_act", 32'(bus.period_act), 6);
    chk("wrap-write pending", 32'(bus.pending), 1);
    idle(6);
    chk("next wrap period_act", 32'(bus.period_act), 10);
    chk("next wrap pending", 32'(bus.pending), 0);

    // Forced shrink below CNT: count through 2^16-1 before the new period takes hold.
    drive(1, 0, 20);
    drive(1, 3, 3);
    chk("force period_act 20", 32'(bus.period_act), 20);
    for (int i = 0; i < 100 && m_cnt != 14; i++) idle(1);
    drive(1, 0, 4);
    drive(1, 3, 3);
    chk("shrink cnt 16", 32'(bus.cnt), 16);
    chk("shrink period_act", 32'(bus.period_act), 4);
    idle(65519);
    chk("shrink cnt max", 32'(bus.cnt), 65535);
    idle(1);
    chk("overflow cnt", 32'(bus.cnt), 0);
    chk("overflow no tick", 32'(bus.period_tick), 0);
    idle(4);
    chk("new period tick", 32'(bus.period_tick), 1);

    // Interrupt set/clear priority.
    chk("irq after wrap", 32'(bus.irq), 32'(IrqOn));
    drive(1, 3, 5);
    chk("irq cleared", 32'(bus.irq), 0);
    idle(2);
    drive(1, 3, 5);
    chk("irq set wins", 32'(bus.irq), 32'(IrqOn));
    idle(1);
    chk("irq sticky", 32'(bus.irq), 32'(IrqOn));

    // Reset mid-run takes effect without a clock edge.
    idle(2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      bit we;
      int a, d;
      we = ($urandom_range(0, 2) == 0);
      a  = $urandom_range(0, 3);
      if (a == 3) begin
        d = ($urandom_range(0, 3) != 0) ? 1 : 0;
        if ($urandom_range(0, 3) == 0) d += 4;
        // Only force when the new period cannot strand CNT above it.
        if ($urandom_range(0, 3) == 0 && (m_sh[0] < 2 || m_sh[0] >= m_cnt + 2)) d += 2;
      end else if (a == 0) begin
        d = $urandom_range(0, 12);
      end else begin
        d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : $urandom_range(0, 12);
      end
      drive(we, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
